// File: rtl/adc_spi_responder_pkg.sv
// Shared constants and state type for the ADC-style SPI responder.
package adc_spi_pkg;
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned LEAD_ZEROS = 4;
    localparam int unsigned SAMPLE_W   = 12;
    localparam int unsigned CH_W       = 3;
    localparam int unsigned NUM_CH     = 8;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
    // bit-counter value of the rise that captures ADD2; ADD1/ADD0 follow
    localparam int unsigned ADDR_K0    = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;
endpackage

// File: rtl/adc_spi_responder_sync.sv
// Multi-flop synchronizer with a selectable reset level.
module spi_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_b,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] pipe;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            pipe <= {STAGES{RESET_VAL}};
        end else begin
            pipe <= STAGES'({pipe, d});
        end
    end

    assign q = pipe[STAGES-1];
endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder: returns 4 zeros + a 12-bit sample per frame; the address
// received in a frame selects the channel returned in the following frame.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_b,
    input  logic                sclk,
    input  logic                cs_b,
    input  logic                din,
    output logic                dout,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [SAMPLE_W-1:0] wr_data,
    output logic [CH_W-1:0]     cur_ch,
    output logic                frame_done,
    output logic                frame_abort
);
    logic sclk_s, cs_s, din_s;
    logic sclk_q, cs_q;
    logic [SYNC_STAGES-1:0] settle;
    logic armed;
    logic sclk_rise_c, sclk_fall_c, cs_fall_c, cs_rise_c;

    state_t              state, state_n;
    logic [CNT_W-1:0]    k, k_n;
    logic [CH_W-1:0]     addr, addr_n, cur_ch_n;
    logic [SAMPLE_W-1:0] snap, snap_n;
    logic                dout_n, done_n, abort_n;
    logic [CNT_W-1:0]    bit_idx_c;
    logic [CH_W-1:0]     addr_idx_c;
    logic [SAMPLE_W-1:0] samples [NUM_CH];

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
        .clk(clk), .reset_b(reset_b), .d(sclk), .q(sclk_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset_b(reset_b), .d(cs_b), .q(cs_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
        .clk(clk), .reset_b(reset_b), .d(din), .q(din_s));

    // Edge history; arming waits until a real high cs_b has passed the
    // synchronizer so a cs_b held low through reset cannot start a frame.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sclk_q <= 1'b1;
            cs_q   <= 1'b1;
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            sclk_q <= sclk_s;
            cs_q   <= cs_s;
            settle <= SYNC_STAGES'({settle, 1'b1});
            armed  <= armed | (settle[SYNC_STAGES-1] & cs_s);
        end
    end

    assign sclk_rise_c = sclk_s & ~sclk_q;
    assign sclk_fall_c = ~sclk_s & sclk_q;
    assign cs_fall_c   = armed & cs_q & ~cs_s;
    assign cs_rise_c   = cs_s & ~cs_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int unsigned i = 0; i < NUM_CH; i++) samples[i] <= '0;
        end else if (wr_en) begin
            samples[wr_ch] <= wr_data;
        end
    end

    // Write-first read used for every snapshot
    function automatic logic [SAMPLE_W-1:0] sample_rd(input logic [CH_W-1:0] ch);
        return (wr_en && (wr_ch == ch)) ? wr_data : samples[ch];
    endfunction

    assign bit_idx_c  = CNT_W'(FRAME_BITS - 1) - k;
    assign addr_idx_c = CH_W'(ADDR_K0 + CH_W - 1) - CH_W'(k);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n  = state;
        k_n      = k;
        addr_n   = addr;
        cur_ch_n = cur_ch;
        snap_n   = snap;
        dout_n   = dout;
        done_n   = 1'b0;
        abort_n  = 1'b0;
        case (state)
            IDLE: begin
                dout_n = 1'b0;
                if (cs_fall_c) begin
                    state_n  = ACTIVE;
                    k_n      = '0;
                    addr_n   = '0;
                    cur_ch_n = '0;
                    snap_n   = sample_rd('0);
                end
            end
            ACTIVE: begin
                if (cs_rise_c) begin
                    state_n = IDLE;
                    dout_n  = 1'b0;
                    k_n     = '0;
                    addr_n  = '0;
                    abort_n = (k != '0);
                end else if (sclk_rise_c) begin
                    k_n = k + 1'b1;
                    if (k >= CNT_W'(ADDR_K0) && k < CNT_W'(ADDR_K0 + CH_W)) begin
                        addr_n[addr_idx_c] = din_s;
                    end
                    if (k == CNT_W'(FRAME_BITS - 1)) begin
                        done_n   = 1'b1;
                        cur_ch_n = addr;
                        snap_n   = sample_rd(addr);
                    end
                end else if (sclk_fall_c) begin
                    // k already points at the frame position being driven
                    dout_n = (k < CNT_W'(LEAD_ZEROS)) ? 1'b0 : snap[bit_idx_c];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            k           <= '0;
            addr        <= '0;
            cur_ch      <= '0;
            snap        <= '0;
            dout        <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            k           <= k_n;
            addr        <= addr_n;
            cur_ch      <= cur_ch_n;
            snap        <= snap_n;
            dout        <= dout_n;
            frame_done  <= done_n;
            frame_abort <= abort_n;
        end
    end
endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: SPI master at clk/8 against a frame-level model.
module tb_adc_spi_responder;
    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        sclk = 1'b1;
    logic        cs_b = 1'b1;
    logic        din = 1'b0;
    logic        dout;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_ch = '0;
    logic [11:0] wr_data = '0;
    logic [2:0]  cur_ch;
    logic        frame_done;
    logic        frame_abort;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int exp_done = 0;
    int exp_abort = 0;

    logic [11:0] mem [8];
    logic [11:0] exp_snap = '0;
    logic [2:0]  exp_cur = '0;
    logic        exp_dout = 1'b0;

    adc_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset_b(reset_b), .sclk(sclk), .cs_b(cs_b), .din(din),
        .dout(dout), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .cur_ch(cur_ch), .frame_done(frame_done), .frame_abort(frame_abort));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
        if (frame_abort === 1'b1) abort_cnt <= abort_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] ch, input logic [11:0] val);
        @(negedge clk);
        wr_en = 1'b1; wr_ch = ch; wr_data = val;
        mem[ch] = val;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic cs_fall();
        @(negedge clk);
        cs_b = 1'b0;
        din = 1'($urandom);
        repeat (4) @(negedge clk);
        exp_cur = '0; exp_snap = mem[0]; exp_dout = 1'b0;
        chk("cur_ch_at_start", cur_ch, exp_cur);
        chk("dout_at_start", dout, exp_dout);
    endtask

    task automatic cs_rise(input logic exp_ab);
        @(negedge clk);
        cs_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("frame_abort_pulse", frame_abort, exp_ab);
        @(negedge clk);
        chk("frame_abort_width", frame_abort, 1'b0);
        chk("dout_idle", dout, 1'b0);
        if (exp_ab) exp_abort++;
        exp_dout = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset_mid();
        reset_b = 1'b0;
        #1;
        chk("rst_dout", dout, 1'b0);
        chk("rst_abort", frame_abort, 1'b0);
        chk("rst_cur_ch", cur_ch, 3'd0);
        for (int c = 0; c < 8; c++) mem[c] = '0;
        exp_cur = '0; exp_snap = '0; exp_dout = 1'b0;
        @(negedge clk); @(negedge clk);
        reset_b = 1'b1;
        repeat (6) @(negedge clk);
        // cs_b still low: sclk activity must not start a frame
        for (int i = 0; i < 16; i++) begin
            sclk = 1'b0;
            repeat (4) @(negedge clk);
            chk("post_rst_dout", dout, 1'b0);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
        end
        chk("post_rst_no_frame", done_cnt, exp_done);
    endtask

    // One SPI frame of nrise rising edges; optional mid-frame write (rise 8),
    // write in the snapshot clk (rise 15), and reset after rise rst_at.
    task automatic frame(input logic [2:0] addr, input int nrise, input int rst_at,
                         input logic mw, input logic [2:0] mch, input logic [11:0] mval,
                         input logic sw, input logic [2:0] sch, input logic [11:0] sval);
        logic [15:0] word;
        word = {4'b0000, exp_snap};
        chk("cur_ch_frame", cur_ch, exp_cur);
        for (int i = 0; i < nrise; i++) begin
            @(negedge clk);
            sclk = 1'b0;
            din = (i == 2) ? addr[2] : (i == 3) ? addr[1] : (i == 4) ? addr[0] : 1'($urandom);
            @(posedge clk); @(posedge clk); #1;
            chk("dout_hold", dout, exp_dout);
            @(posedge clk); #1;
            exp_dout = word[15-i];
            chk("dout_lat3", dout, exp_dout);
            @(negedge clk);
            @(negedge clk);
            sclk = 1'b1;
            if (mw && i == 8) begin
                wr_en = 1'b1; wr_ch = mch; wr_data = mval; mem[mch] = mval;
            end
            @(negedge clk);
            wr_en = 1'b0;
            if (i == rst_at) begin
                do_reset_mid();
                return;
            end
            @(negedge clk);
            if (sw && i == 15) begin
                wr_en = 1'b1; wr_ch = sch; wr_data = sval; mem[sch] = sval;
            end
            @(negedge clk);
            wr_en = 1'b0;
            if (i == 15) begin
                exp_snap = mem[addr]; exp_cur = addr; exp_done++;
            end
            chk("frame_done", frame_done, (i == 15));
            chk("cur_ch", cur_ch, exp_cur);
        end
    endtask

    initial begin
        logic [2:0]  a, mc, sc;
        logic [11:0] mv, sv;
        for (int c = 0; c < 8; c++) mem[c] = '0;
        repeat (3) @(negedge clk);
        chk("reset_dout", dout, 1'b0);
        chk("reset_cur_ch", cur_ch, 3'd0);
        chk("reset_done", frame_done, 1'b0);
        chk("reset_abort", frame_abort, 1'b0);
        reset_b = 1'b1;
        repeat (6) @(negedge clk);

        // sclk toggling with cs_b high is ignored
        wr(3'd0, 12'h70E);
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b0; repeat (4) @(negedge clk);
            chk("idle_dout", dout, 1'b0);
            sclk = 1'b1; repeat (4) @(negedge clk);
        end

        // continuous frames: ch0, then ch3, then ch5
        wr(3'd3, 12'hABC);
        wr(3'd5, 12'h123);
        cs_fall();
        frame(3'd3, 16, -1, 1'b0, 3'd0, 12'h0, 1'b0, 3'd0, 12'h0);
        frame(3'd5, 16, -1, 1'b0, 3'd0, 12'h0, 1'b0, 3'd0, 12'h0);
        frame(3'd0, 16, -1, 1'b0, 3'd0, 12'h0, 1'b0, 3'd0, 12'h0);
        cs_rise(1'b0);

        // abort after 9 rises keeps cur_ch, restart begins clean
        cs_fall();
        frame(3'd4, 16, -1, 1'b0, 3'd0, 12'h0, 1'b0, 3'd0, 12'h0);
        frame(3'd6, 9, -1, 1'b0, 3'd0, 12'h0, 1'b0, 3'd0, 12'h0);
        cs_rise(1'b1);
        chk("cur_ch_after_abort", cur_ch, exp_cur);
        cs_fall();
        frame(3'd1, 16, -1, 1'b0, 3'd0, 12'h0, 1'b0, 3'd0, 12'h0);

        // in-flight frame isolation and write-first snapshot on ch2
        wr(3'd2, 12'h2A1);
        frame(3'd2, 16, -1, 1'b0, 3'd0, 12'h0, 1'b0, 3'd0, 12'h0);
        frame(3'd2, 16, -1, 1'b1, 3'd2, 12'h555, 1'b1, 3'd2, 12'hFFF);
        frame(3'd0, 16, -1, 1'b0, 3'd0, 12'h0, 1'b0, 3'd0, 12'h0);

        // randomized back-to-back frames with writes racing the snapshot
        for (int f = 0; f < 10; f++) begin
            a  = 3'($urandom_range(0, 7));
            mc = 3'($urandom_range(0, 7));
            mv = 12'($urandom);
            sc = ($urandom_range(0, 1) == 1) ? a : 3'($urandom_range(0, 7));
            sv = 12'($urandom);
            frame(a, 16, -1, 1'($urandom), mc, mv, 1'($urandom), sc, sv);
        end

        // reset during bit 7, then a fresh frame returns zeros
        frame(3'd5, 16, 7, 1'b0, 3'd0, 12'h0, 1'b0, 3'd0, 12'h0);
        cs_rise(1'b0);
        cs_fall();
        a = 3'($urandom_range(1, 7));
        frame(a, 16, -1, 1'b0, 3'd0, 12'h0, 1'b0, 3'd0, 12'h0);
        frame(3'd0, 16, -1, 1'b0, 3'd0, 12'h0, 1'b0, 3'd0, 12'h0);
        cs_rise(1'b0);

        chk("frame_done_count", done_cnt, exp_done);
        chk("frame_abort_count", abort_cnt, exp_abort);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of clk-domain synchronizer flops on sclk, cs_b and din.
REQ-002 SHALL have port clk  input  1  system clock; must run at least 8x sclk.
REQ-003 SHALL have port reset_b  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port sclk  input  1  SPI clock from master; idles high.
REQ-005 SHALL have port cs_b  input  1  SPI chip select from master, active-low.
REQ-006 SHALL have port din  input  1  SPI address data from master, MSB first.
REQ-007 SHALL have port dout  output  1  SPI sample data to master.
REQ-008 SHALL have port wr_en  input  1  sample-register write strobe.
REQ-009 SHALL have port wr_ch  input  3  channel index for the write.
REQ-010 SHALL have port wr_data  input  12  sample value for the write.
REQ-011 SHALL have port cur_ch  output  3  channel being shifted out in the current frame.
REQ-012 SHALL have port frame_done  output  1  one-clk pulse on completion of a 16-bit frame.
REQ-013 SHALL have port frame_abort  output  1  one-clk pulse when cs_b rises mid-frame.

Function
REQ-014 SHALL hold eight 12-bit sample registers; wr_en=1 writes wr_data to register wr_ch on the clk rising edge; writes are allowed at any time.
REQ-015 SHALL synchronize sclk, cs_b and din through SYNC_STAGES flops and detect sclk rise/fall and cs_b fall/rise from the synchronized values.
REQ-016 SHALL implement states IDLE (cs_b high) and ACTIVE (cs_b low); IDLE->ACTIVE on synchronized cs_b fall; ACTIVE->IDLE on synchronized cs_b rise.
REQ-017 On IDLE->ACTIVE SHALL clear the bit counter to 0, set cur_ch to 0, snapshot sample register 0 into a 12-bit shift source, and drive dout=0.
REQ-018 SHALL increment a 4-bit bit counter k on every synchronized sclk rise in ACTIVE; the counter wraps from 15 to 0.
REQ-019 SHALL sample din at rises with k=2,3,4 into captured address bits ADD2, ADD1 and ADD0 respectively.
REQ-020 On the sclk fall after rise k SHALL drive the frame bit at position p=(k+1) mod 16: 0 for p<4, otherwise snapshot bit [15-p]; DB11 is first, DB0 is last.
REQ-021 SHALL register dout so it changes exactly SYNC_STAGES+1 clk cycles after the external sclk fall; dout SHALL NOT change at any other time in ACTIVE.
REQ-022 At rise k=15 SHALL pulse frame_done, load cur_ch with the captured address, and snapshot that channel's register for the next frame (pipelined: frame N returns the address received in frame N-1).
REQ-023 SHALL continue back-to-back frames while cs_b stays low, with no idle bit between them.
REQ-024 A write that lands in the same clk as a snapshot SHALL be included in the snapshot if it targets the snapshotted channel (write-first); later writes SHALL NOT alter the frame in flight.
REQ-025 On cs_b rise with k!=0 SHALL pulse frame_abort, discard the partial address, and leave cur_ch unchanged.
REQ-026 In IDLE SHALL hold dout=0 and ignore sclk and din.
REQ-027 If a cs_b fall and an sclk edge are detected in the same clk, the cs_b fall SHALL take priority and the sclk edge SHALL be ignored.

Reset
REQ-028 On reset_b low SHALL asynchronously force: state IDLE, k=0, dout=0, cur_ch=0, frame_done=0, frame_abort=0, all sample registers 0, synchronizer flops to the idle levels (sclk=1, cs_b=1, din=0).
REQ-029 Reset asserted mid-frame SHALL abort silently, without a frame_abort pulse; after reset release, a new frame SHALL start only on a fresh cs_b fall.

Structure
REQ-030 Package adc_spi_pkg SHALL hold FRAME_BITS=16, LEAD_ZEROS=4, SAMPLE_W=12, CH_W=3, NUM_CH=8 and the state enum {IDLE, ACTIVE}.
REQ-031 SHALL instantiate a sub-module spi_sync (a parameterized SYNC_STAGES-flop synchronizer with a reset value) once per SPI input.

Verification
REQ-032 Write ch0=0x70E; cs_b low; master sends ADD=3 -> frame 1 dout=0000_0111_0000_1110, cur_ch=0, frame_done pulse at the 16th rise.
REQ-033 Write ch3=0xABC, ch5=0x123; continuous frames with ADD=3 then ADD=5 then ADD=0 -> frames return ch0, then 0xABC, then 0x123; cur_ch sequence 0,3,5.
REQ-034 Raise cs_b after 9 rises -> frame_abort pulse, cur_ch unchanged; next cs_b fall restarts at k=0, cur_ch=0, leading zeros first.
REQ-035 Write ch2=0x555 during the frame that returns ch2, and write ch2=0xFFF in the exact snapshot clk -> in-flight frame unchanged; snapshot yields 0xFFF.
REQ-036 Assert reset_b at bit 7 of a frame -> dout=0, all sample registers 0, no frame_abort; the next full frame returns 0x000.
REQ-037 With clk = 8x sclk, measure the external sclk fall to dout change -> exactly 3 clk cycles for every data bit.
